camera_capture_ctrl: RTL and testbench
======================================

Name: camera_capture_ctrl

Overview:
- Sequences capture of one (or continuous) frames from the OV7670-style camera byte stream (vsync/href/8-bit data), or from its simulator.
- Assembles byte pairs into RGB565 pixels and generates linear frame-buffer write strobes and addresses.
- Reports frame completion and line/frame geometry errors.
- Sits between the camera pins (or simulator) and the frame-buffer BRAM write port.

Parameters:
- WIDTH, 640, pixels per line (2 bytes per pixel).
- HEIGHT, 480, lines per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT.
- CONTINUOUS, 0, 1 = re-arm automatically after each frame; 0 = single shot per start.

Ports:
- pclk  in  1  camera pixel clock; the only clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  arm request; one-cycle pulse or level; sampled only in IDLE.
- vsync  in  1  camera vertical sync; high = inter-frame gap.
- href  in  1  camera line valid; high = data byte valid this cycle.
- data  in  8  camera data byte.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  write address, = y*WIDTH + x.
- wr_data  out  16  RGB565 pixel, {first byte, second byte}.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- line_err  out  1  sticky; a line had a pixel count != WIDTH or an odd byte count.
- frame_err  out  1  sticky; a frame had a line count != HEIGHT, or the address space overflowed.

Behaviour:
- Reset: state=IDLE; all outputs 0; byte phase, x/pixel counter, line counter and address counter = 0.
- Reset mid-frame: the frame is abandoned, nothing is flushed, and the block returns to IDLE.
- States and transitions:
  - IDLE: on start=1, go to ARM; clear line_err and frame_err.
  - ARM: wait for vsync=1, then go to SYNC.
  - SYNC: wait for vsync=0 (frame start), then go to CAPTURE; counters = 0. Entering mid-frame never captures a partial frame.
  - CAPTURE: capture bytes while href=1. vsync=1 ends the frame and moves to DONE.
  - DONE: lasts one cycle and drives frame_done=1. If frame_line_cnt != HEIGHT, set frame_err. Then go to SYNC if CONTINUOUS=1 (vsync is already high), otherwise to IDLE.
- Pixel assembly in CAPTURE:
  - href=1 with phase 0: latch data into hi_byte; phase becomes 1.
  - href=1 with phase 1: phase becomes 0. On the next cycle, wr_en=1, wr_data={hi_byte,data}, wr_addr=addr_cnt. Latency is 1 cycle after the second byte is sampled.
  - After each write: addr_cnt+1 and x_cnt+1.
- Line end (href 1->0 edge, detected with a registered href):
  - If x_cnt != WIDTH or phase=1, set line_err.
  - Then x_cnt=0, phase=0 (an odd byte is discarded), line_cnt+1.
- Address bound:
  - If a pixel would be written with addr_cnt = WIDTH*HEIGHT, suppress wr_en and set frame_err. addr_cnt saturates and never wraps.
  - A line with more than WIDTH pixels keeps writing linearly only up to that bound.
- Simultaneous events:
  - vsync rising while href=1 or a pixel is pending: the pending write still issues on the same cycle DONE asserts frame_done, then the frame ends.
  - start during busy is ignored.
- wr_en is never asserted outside CAPTURE or DONE. wr_data and wr_addr hold their last values when wr_en=0.
- Counter widths:
  - x_cnt: clog2(WIDTH+1).
  - line_cnt: clog2(HEIGHT+1), saturating.
  - addr_cnt: ADDR_W.

Decomposition:
- Shared package camera_pkg holds:
  - the state encoding localparams (S_IDLE, S_ARM, S_SYNC, S_CAPTURE, S_DONE);
  - the default WIDTH/HEIGHT constants;
  - the RGB565 field positions, also used by the display path.
- One sub-module is natural: camera_byte_pair. It contains the phase toggle, hi_byte latch, href edge detect and odd-byte flag, and outputs pix_valid, pix_data and line_end.
- The top level holds the FSM, counters and error flags.

Test Plan:
- Nominal frame (WIDTH=4, HEIGHT=2, CONTINUOUS=0). Stimulus: start, vsync pulse, two lines of 8 bytes 0xAA,0x0B,...; vsync high. Response:
  - wr_en pulses exactly 8 times at addresses 0..7;
  - first wr_data=16'hAA0B;
  - frame_done asserted for 1 cycle, then busy=0;
  - line_err=0 and frame_err=0.
- Arm mid-frame: assert start while vsync=0 and href is toggling. Response: no wr_en until a full vsync high->low cycle has passed; the capture then starts at address 0.
- Short line plus odd byte: a line of 7 bytes. Response:
  - 3 writes for that line;
  - line_err=1 (sticky);
  - the next line's first pixel is assembled from a fresh phase 0.
- Overflow: 3 lines of 4 pixels with HEIGHT=2. Response:
  - writes at addresses 0..7 only;
  - frame_err=1;
  - no write at address 8.
- Continuous mode (CONTINUOUS=1): two frames back to back. Response:
  - two frame_done pulses;
  - the second frame restarts at address 0;
  - busy stays 1 throughout.
- Reset mid-operation: assert rst during the second line. Response: on the next cycle all outputs = 0, state = IDLE, and a later start captures cleanly.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared camera-path definitions: capture FSM states, default frame geometry
// and RGB565 field positions (also used by the display path).
package camera_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_SYNC    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } cam_state_e;

  localparam int CAM_WIDTH  = 640;
  localparam int CAM_HEIGHT = 480;

  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_MSB = 4;
  localparam int RGB565_B_LSB = 0;

endpackage

// File: rtl/camera_byte_pair.sv
// Pairs camera bytes into 16-bit pixels and flags line ends (href falling edge).
// Phase and href history are held clear whenever capture is disabled.
module camera_byte_pair (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        href_i,
  input  logic [7:0]  data_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_data_o,
  output logic        line_end_o,
  output logic        line_odd_o
);

  logic       phase_q;
  logic [7:0] hi_byte_q;
  logic       href_q;

  // Pixel completes on the second byte; line end on registered-href fall.
  always_comb begin
    pix_valid_o = en_i & href_i & phase_q;
    pix_data_o  = {hi_byte_q, data_i};
    line_end_o  = en_i & href_q & ~href_i;
    line_odd_o  = phase_q;
  end

  // Phase toggles per valid byte; any gap in href drops a dangling odd byte.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      phase_q   <= 1'b0;
      hi_byte_q <= 8'h00;
      href_q    <= 1'b0;
    end else if (!en_i) begin
      phase_q   <= 1'b0;
      hi_byte_q <= hi_byte_q;
      href_q    <= 1'b0;
    end else begin
      href_q <= href_i;
      if (href_i) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          hi_byte_q <= data_i;
        end else begin
          hi_byte_q <= hi_byte_q;
        end
      end else begin
        phase_q   <= 1'b0;
        hi_byte_q <= hi_byte_q;
      end
    end
  end

endmodule

// File: rtl/camera_capture_ctrl.sv
// Camera capture sequencer: arms on start, captures whole frames only, writes
// RGB565 pixels linearly into the frame buffer and reports geometry errors.
module camera_capture_ctrl
  import camera_pkg::*;
#(
  parameter int WIDTH      = CAM_WIDTH,
  parameter int HEIGHT     = CAM_HEIGHT,
  parameter int ADDR_W     = 19,
  parameter int CONTINUOUS = 0
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(HEIGHT + 1);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(WIDTH * HEIGHT);

  cam_state_e        state_q, state_d;
  logic [XW-1:0]     x_cnt_q, x_cnt_d;
  logic              x_over_q, x_over_d;
  logic [LW-1:0]     line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;

  logic              capture_s;
  logic              pix_valid_s;
  logic [15:0]       pix_data_s;
  logic              line_end_s;
  logic              line_odd_s;
  logic              addr_full_s;

  assign capture_s   = (state_q == S_CAPTURE);
  assign addr_full_s = ({1'b0, addr_cnt_q} == ADDR_LIMIT);

  camera_byte_pair u_byte_pair (
    .pclk_i      (pclk),
    .rst_i       (rst),
    .en_i        (capture_s),
    .href_i      (href),
    .data_i      (data),
    .pix_valid_o (pix_valid_s),
    .pix_data_o  (pix_data_s),
    .line_end_o  (line_end_s),
    .line_odd_o  (line_odd_s)
  );

  // Frame sequencing; DONE always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start)  state_d = S_ARM;     else state_d = S_IDLE;
      S_ARM:     if (vsync)  state_d = S_SYNC;    else state_d = S_ARM;
      S_SYNC:    if (!vsync) state_d = S_CAPTURE; else state_d = S_SYNC;
      S_CAPTURE: if (vsync)  state_d = S_DONE;    else state_d = S_CAPTURE;
      S_DONE:    if (CONTINUOUS != 0) state_d = S_SYNC; else state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Counters, write port and error flags.
  always_comb begin
    x_cnt_d      = x_cnt_q;
    x_over_d     = x_over_q;
    line_cnt_d   = line_cnt_q;
    addr_cnt_d   = addr_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    line_err_d   = line_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);

    if ((state_q == S_IDLE) && start) begin
      line_err_d  = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      line_err_d  = line_err_q;
    end

    if ((state_q == S_SYNC) && !vsync) begin
      x_cnt_d    = '0;
      x_over_d   = 1'b0;
      line_cnt_d = '0;
      addr_cnt_d = '0;
    end else begin
      x_cnt_d    = x_cnt_q;
    end

    if (pix_valid_s) begin
      // Past the end of the buffer the pixel is dropped and the address holds.
      if (addr_full_s) begin
        frame_err_d = 1'b1;
      end else begin
        wr_en_d    = 1'b1;
        wr_addr_d  = addr_cnt_q;
        wr_data_d  = pix_data_s;
        addr_cnt_d = addr_cnt_q + ADDR_W'(1);
      end
      if (x_cnt_q == XW'(WIDTH)) begin
        x_over_d = 1'b1;
      end else begin
        x_cnt_d = x_cnt_q + XW'(1);
      end
    end else begin
      wr_en_d = 1'b0;
    end

    if (line_end_s) begin
      if ((x_cnt_q != XW'(WIDTH)) || x_over_q || line_odd_s) begin
        line_err_d = 1'b1;
      end else begin
        line_err_d = line_err_q;
      end
      x_cnt_d  = '0;
      x_over_d = 1'b0;
      if (line_cnt_q != {LW{1'b1}}) begin
        line_cnt_d = line_cnt_q + LW'(1);
      end else begin
        line_cnt_d = line_cnt_q;
      end
    end else begin
      x_over_d = x_over_d;
    end

    if ((state_q == S_DONE) && (line_cnt_q != LW'(HEIGHT))) begin
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_d;
    end
  end

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_cnt_q      <= '0;
      x_over_q     <= 1'b0;
      line_cnt_q   <= '0;
      addr_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 16'h0000;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      x_over_q     <= x_over_d;
      line_cnt_q   <= line_cnt_d;
      addr_cnt_q   <= addr_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed bench for camera_capture_ctrl with a 4x2 frame: one single-shot and
// one continuous instance share the camera stream, each with its own start/rst.
module tb_camera_capture_ctrl;

  logic       pclk = 1'b0;
  logic       rst0, rst1, start0, start1;
  logic       vsync, href;
  logic [7:0] data;

  logic        wr_en0, busy0, frame_done0, line_err0, frame_err0;
  logic [3:0]  wr_addr0;
  logic [15:0] wr_data0;
  logic        wr_en1, busy1, frame_done1, line_err1, frame_err1;
  logic [3:0]  wr_addr1;
  logic [15:0] wr_data1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  a0_q[$];
  logic [15:0] d0_q[$];
  logic [3:0]  a1_q[$];
  int fd0_cnt = 0;
  int fd1_cnt = 0;
  int busy1_low = 0;
  logic watch1 = 1'b0;

  always #5 pclk = ~pclk;

  camera_capture_ctrl #(.WIDTH(4), .HEIGHT(2), .ADDR_W(4), .CONTINUOUS(0)) dut0 (
    .pclk(pclk), .rst(rst0), .start(start0), .vsync(vsync), .href(href), .data(data),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0),
    .frame_done(frame_done0), .line_err(line_err0), .frame_err(frame_err0)
  );

  camera_capture_ctrl #(.WIDTH(4), .HEIGHT(2), .ADDR_W(4), .CONTINUOUS(1)) dut1 (
    .pclk(pclk), .rst(rst1), .start(start1), .vsync(vsync), .href(href), .data(data),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1),
    .frame_done(frame_done1), .line_err(line_err1), .frame_err(frame_err1)
  );

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge pclk) begin
    if (wr_en0) begin
      a0_q.push_back(wr_addr0);
      d0_q.push_back(wr_data0);
    end
    if (wr_en1) a1_q.push_back(wr_addr1);
    if (frame_done0) fd0_cnt++;
    if (frame_done1) fd1_cnt++;
    if (watch1 && !busy1) busy1_low++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [15:0] exp_pix(input int p);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'(8'hAA + p);
    lo = 8'(8'h0B + p);
    return {hi, lo};
  endfunction

  // Byte i of a line: even = high byte, odd = low byte of pixel p0 + i/2.
  task automatic send_line(input int nbytes, input int p0);
    for (int i = 0; i < nbytes; i++) begin
      href = 1'b1;
      data = (i % 2 == 0) ? 8'(8'hAA + p0 + i / 2) : 8'(8'h0B + p0 + i / 2);
      tick();
    end
    href = 1'b0;
    data = 8'h00;
    tick();
    tick();
  endtask

  task automatic frame_start();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic frame_end();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    int base;
    int fdb;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    vsync = 1'b0; href = 1'b0; data = 8'h00;
    repeat (3) tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    check("rst_wr_en",      {31'd0, wr_en0},      32'd0);
    check("rst_wr_addr",    {28'd0, wr_addr0},    32'd0);
    check("rst_wr_data",    {16'd0, wr_data0},    32'd0);
    check("rst_busy",       {31'd0, busy0},       32'd0);
    check("rst_frame_done", {31'd0, frame_done0}, 32'd0);
    check("rst_line_err",   {31'd0, line_err0},   32'd0);
    check("rst_frame_err",  {31'd0, frame_err0},  32'd0);
    check("rst_busy1",      {31'd0, busy1},       32'd0);

    // Nominal frame.
    base = a0_q.size(); fdb = fd0_cnt;
    pulse_start0();
    check("nom_busy_armed", {31'd0, busy0}, 32'd1);
    frame_start();
    send_line(8, 0);
    send_line(8, 4);
    href = 1'b0; vsync = 1'b1;
    tick();
    check("nom_frame_done", {31'd0, frame_done0}, 32'd1);
    tick();
    check("nom_done_1cyc", {31'd0, frame_done0}, 32'd0);
    check("nom_busy_off",  {31'd0, busy0},       32'd0);
    repeat (2) tick();
    check("nom_wr_count", a0_q.size() - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < a0_q.size()) begin
        check($sformatf("nom_addr%0d", i), {28'd0, a0_q[base + i]}, 32'(i));
        check($sformatf("nom_data%0d", i), {16'd0, d0_q[base + i]}, {16'd0, exp_pix(i)});
      end
    end
    check("nom_first_data", (base < d0_q.size()) ? {16'd0, d0_q[base]} : 32'hDEAD, 32'h0000AA0B);
    check("nom_fd_count",  fd0_cnt - fdb, 32'd1);
    check("nom_line_err",  {31'd0, line_err0},  32'd0);
    check("nom_frame_err", {31'd0, frame_err0}, 32'd0);

    // Arm in the middle of a frame: nothing written until a full vsync cycle.
    vsync = 1'b0;
    repeat (2) tick();
    base = a0_q.size();
    for (int i = 0; i < 8; i++) begin
      href   = 1'b1;
      data   = 8'(8'h40 + i);
      start0 = (i == 2);
      tick();
    end
    start0 = 1'b0;
    href = 1'b0;
    repeat (2) tick();
    send_line(8, 20);
    check("arm_busy",  {31'd0, busy0}, 32'd1);
    check("arm_no_wr", a0_q.size() - base, 32'd0);
    frame_start();
    send_line(8, 0);
    send_line(8, 4);
    frame_end();
    check("arm_wr_count", a0_q.size() - base, 32'd8);
    check("arm_first_addr", (base < a0_q.size()) ? {28'd0, a0_q[base]} : 32'hDEAD, 32'd0);
    check("arm_first_data", (base < d0_q.size()) ? {16'd0, d0_q[base]} : 32'hDEAD, 32'h0000AA0B);

    // Short line with an odd trailing byte, then a normal line.
    base = a0_q.size();
    pulse_start0();
    frame_start();
    send_line(7, 0);
    check("odd_wr_count", a0_q.size() - base, 32'd3);
    check("odd_line_err", {31'd0, line_err0}, 32'd1);
    send_line(8, 10);
    check("odd_sticky", {31'd0, line_err0}, 32'd1);
    frame_end();
    check("odd_total_wr", a0_q.size() - base, 32'd7);
    check("odd_l2_addr", (base + 3 < a0_q.size()) ? {28'd0, a0_q[base + 3]} : 32'hDEAD, 32'd3);
    check("odd_l2_data", (base + 3 < d0_q.size()) ? {16'd0, d0_q[base + 3]} : 32'hDEAD, 32'h0000B415);
    check("odd_frame_err", {31'd0, frame_err0}, 32'd0);

    // Three lines into a two-line buffer.
    base = a0_q.size();
    pulse_start0();
    check("ovf_errs_cleared", {30'd0, line_err0, frame_err0}, 32'd0);
    frame_start();
    send_line(8, 0);
    send_line(8, 4);
    send_line(8, 8);
    frame_end();
    check("ovf_wr_count", a0_q.size() - base, 32'd8);
    check("ovf_last_addr", (base + 7 < a0_q.size()) ? {28'd0, a0_q[base + 7]} : 32'hDEAD, 32'd7);
    check("ovf_frame_err", {31'd0, frame_err0}, 32'd1);

    // Continuous mode: two back-to-back frames on the second instance.
    base = a1_q.size(); fdb = fd1_cnt;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    watch1 = 1'b1;
    frame_start();
    send_line(8, 0);
    send_line(8, 4);
    frame_start();
    send_line(8, 0);
    send_line(8, 4);
    frame_end();
    check("cont_busy_end", {31'd0, busy1}, 32'd1);
    watch1 = 1'b0;
    check("cont_fd_count", fd1_cnt - fdb, 32'd2);
    check("cont_wr_count", a1_q.size() - base, 32'd16);
    check("cont_f2_addr0", (base + 8 < a1_q.size()) ? {28'd0, a1_q[base + 8]} : 32'hDEAD, 32'd0);
    check("cont_busy_low", busy1_low, 32'd0);
    check("cont_frame_err", {31'd0, frame_err1}, 32'd0);

    // Reset during the second line, then a clean capture.
    pulse_start0();
    frame_start();
    send_line(8, 0);
    for (int i = 0; i < 3; i++) begin
      href = 1'b1;
      data = 8'(8'h60 + i);
      tick();
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    href = 1'b0;
    check("mrst_wr_en",      {31'd0, wr_en0},      32'd0);
    check("mrst_wr_addr",    {28'd0, wr_addr0},    32'd0);
    check("mrst_wr_data",    {16'd0, wr_data0},    32'd0);
    check("mrst_busy",       {31'd0, busy0},       32'd0);
    check("mrst_frame_done", {31'd0, frame_done0}, 32'd0);
    check("mrst_errs",       {30'd0, line_err0, frame_err0}, 32'd0);
    tick();
    base = a0_q.size(); fdb = fd0_cnt;
    frame_start();
    send_line(8, 0);
    check("mrst_idle_no_wr", a0_q.size() - base, 32'd0);
    pulse_start0();
    frame_start();
    send_line(8, 0);
    send_line(8, 4);
    frame_end();
    check("mrst_wr_count", a0_q.size() - base, 32'd8);
    check("mrst_first_addr", (base < a0_q.size()) ? {28'd0, a0_q[base]} : 32'hDEAD, 32'd0);
    check("mrst_last_data", (base + 7 < d0_q.size()) ? {16'd0, d0_q[base + 7]} : 32'hDEAD, {16'd0, exp_pix(7)});
    check("mrst_fd_count", fd0_cnt - fdb, 32'd1);
    check("mrst_clean_errs", {30'd0, line_err0, frame_err0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
